// File: rtl/filter_spad_sequencer.sv
// Filter scratchpad read sequencer: replays the stored filter row (S*C words) P times
// and streams each word to the MAC over valid/ready, tagging the last word of every pass.
module filter_spad_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int MEM_DEPTH  = 224,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] filt_size,
   input  logic [CNT_WIDTH-1:0]  num_chan,
   input  logic [CNT_WIDTH-1:0]  num_pass,
   input  logic                  spad_full,
   output logic                  r_en,
   output logic [ADDR_WIDTH-1:0] r_addr,
   input  logic [DATA_WIDTH-1:0] spad_dout,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic                  w_last,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);
   localparam int PROD_WIDTH = ADDR_WIDTH + CNT_WIDTH;

   typedef enum logic [2:0] {IDLE, WAIT_FULL, RUN, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
   logic [CNT_WIDTH-1:0]  last_pass_q, last_pass_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [CNT_WIDTH-1:0]  pass_q, pass_d;
   logic                  all_issued_q, all_issued_d;
   logic                  r_en_q, r_en_d;
   logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
   logic                  r_last_q, r_last_d;
   logic                  cfg_err_q, cfg_err_d;

   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [DATA_WIDTH-1:0] fifo_data_d [2];
   logic                  fifo_last_q [2];
   logic                  fifo_last_d [2];
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [1:0]            cnt_q, cnt_d;

   logic [PROD_WIDTH-1:0] prod;
   logic                  degenerate;
   logic                  too_big;
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  idx_wrap;

   assign prod       = PROD_WIDTH'(filt_size) * PROD_WIDTH'(num_chan);
   assign degenerate = (filt_size == '0) || (num_chan == '0) || (num_pass == '0);
   assign too_big    = prod > PROD_WIDTH'(MEM_DEPTH);
   assign idx_wrap   = (idx_q == last_addr_q);

   always_comb begin
      state_d      = state_q;
      last_addr_d  = last_addr_q;
      last_pass_d  = last_pass_q;
      idx_d        = idx_q;
      pass_d       = pass_q;
      all_issued_d = all_issued_q;
      r_en_d       = 1'b0;
      r_addr_d     = r_addr_q;
      r_last_d     = r_last_q;
      cfg_err_d    = cfg_err_q;
      fifo_data_d  = fifo_data_q;
      fifo_last_d  = fifo_last_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;

      // The read in flight lands in the FIFO at this edge; its slot was reserved at issue.
      push  = r_en_q;
      pop   = (cnt_q != 2'd0) && w_ready;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

      if (push) begin
         fifo_data_d[wr_ptr_q] = spad_dout;
         fifo_last_d[wr_ptr_q] = r_last_q;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      // Issue only if the word will have a FIFO slot when it returns next cycle.
      issue = ((state_q == RUN) || ((state_q == WAIT_FULL) && spad_full))
              && !all_issued_q && (cnt_d < 2'd2);

      if (issue) begin
         r_en_d   = 1'b1;
         r_addr_d = idx_q;
         r_last_d = idx_wrap;
         if (idx_wrap) begin
            idx_d  = '0;
            pass_d = pass_q + CNT_WIDTH'(1);
            if (pass_q == last_pass_q) begin
               all_issued_d = 1'b1;
            end
         end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               cfg_err_d    = too_big;
               last_addr_d  = ADDR_WIDTH'(prod - PROD_WIDTH'(1));
               last_pass_d  = num_pass - CNT_WIDTH'(1);
               idx_d        = '0;
               pass_d       = '0;
               all_issued_d = 1'b0;
               state_d      = (degenerate || too_big) ? DONE : WAIT_FULL;
            end
         end
         WAIT_FULL: begin
            if (spad_full) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (all_issued_d) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_d == 2'd0) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_addr_q  <= '0;
         last_pass_q  <= '0;
         idx_q        <= '0;
         pass_q       <= '0;
         all_issued_q <= 1'b0;
         r_en_q       <= 1'b0;
         r_addr_q     <= '0;
         r_last_q     <= 1'b0;
         cfg_err_q    <= 1'b0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         cnt_q        <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         state_q      <= state_d;
         last_addr_q  <= last_addr_d;
         last_pass_q  <= last_pass_d;
         idx_q        <= idx_d;
         pass_q       <= pass_d;
         all_issued_q <= all_issued_d;
         r_en_q       <= r_en_d;
         r_addr_q     <= r_addr_d;
         r_last_q     <= r_last_d;
         cfg_err_q    <= cfg_err_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         cnt_q        <= cnt_d;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= fifo_data_d[i];
            fifo_last_q[i] <= fifo_last_d[i];
         end
      end
   end

   assign r_en    = r_en_q;
   assign r_addr  = r_addr_q;
   assign w_valid = (cnt_q != 2'd0);
   assign w_data  = w_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign w_last  = w_valid & fifo_last_q[rd_ptr_q];
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_filter_spad_sequencer.sv
// Directed bench for filter_spad_sequencer: table of jobs with hand-computed timing,
// a behavioural spad with one-cycle read latency, and hand sequences for reset cases.
module tb_filter_spad_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  filt_size;
   logic [7:0]  num_chan;
   logic [7:0]  num_pass;
   logic        spad_full;
   logic        r_en;
   logic [7:0]  r_addr;
   logic [15:0] spad_dout;
   logic [15:0] w_data;
   logic        w_valid;
   logic        w_ready;
   logic        w_last;
   logic        busy;
   logic        done;
   logic        cfg_err;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      int s;
      int c;
      int p;
      int ready_mode;
      int full_delay;
      int restart_cyc;
      int exp_words;
      int exp_first_ren;
      int exp_done;
      int exp_err;
   } vec_t;

   vec_t tbl [10];

   filter_spad_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .filt_size (filt_size),
      .num_chan  (num_chan),
      .num_pass  (num_pass),
      .spad_full (spad_full),
      .r_en      (r_en),
      .r_addr    (r_addr),
      .spad_dout (spad_dout),
      .w_data    (w_data),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_last    (w_last),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int spad_val(input int a);
      return (a * 37 + 4660) & 16'hFFFF;
   endfunction

   // Spad samples r_en/r_addr on the negedge; the DUT captures the word at the next posedge.
   always @(negedge clk) begin
      if (r_en) spad_dout <= 16'(spad_val(int'(r_addr)));
   end

   task automatic check(input int vi, input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL v%0d %s: got %0d, expected %0d", vi, name, act, exp);
      end
   endtask

   function automatic logic ready_of(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      return ((cyc % 4) == 0) || ((cyc % 4) == 3);
   endfunction

   task automatic run_job(input int vi);
      vec_t v;
      int   n, cyc, words, reads, occ, ea, first_ren, done_cyc, err_at_done;
      v         = tbl[vi];
      n         = v.s * v.c;
      cyc       = 0;
      words     = 0;
      reads     = 0;
      occ       = 0;
      ea        = 0;
      first_ren = 0;
      done_cyc  = 0;
      err_at_done = -1;
      filt_size = 8'(v.s);
      num_chan  = 8'(v.c);
      num_pass  = 8'(v.p);
      spad_full = (v.full_delay == 0);
      w_ready   = 1'b0;
      start     = 1'b1;
      while (done_cyc == 0 && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
         start = (v.restart_cyc != 0) && (cyc == v.restart_cyc);
         if (start) begin
            filt_size = 8'd1;
            num_chan  = 8'd1;
            num_pass  = 8'd1;
         end
         spad_full = (cyc > v.full_delay);
         w_ready   = ready_of(v.ready_mode, cyc);
         #1;
         if (cyc == 1) check(vi, "busy_after_start", int'(busy), 1);
         check(vi, "w_valid_vs_occupancy", int'(w_valid), int'(occ != 0));
         if (r_en) begin
            if (first_ren == 0) first_ren = cyc;
            check(vi, "r_addr", int'(r_addr), ea);
            check(vi, "fifo_plus_inflight_le_2", int'(occ <= 1), 1);
            ea = (ea + 1 == n) ? 0 : ea + 1;
            reads++;
         end
         if (w_valid && w_ready) begin
            check(vi, "w_data", int'(w_data), spad_val(words % n));
            check(vi, "w_last", int'(w_last), int'((words % n) == n - 1));
            words++;
         end
         occ = occ + int'(r_en) - int'(w_valid && w_ready);
         if (done) begin
            done_cyc    = cyc;
            err_at_done = int'(cfg_err);
         end
      end
      start = 1'b0;
      check(vi, "done_cycle", done_cyc, v.exp_done);
      check(vi, "first_r_en_cycle", first_ren, v.exp_first_ren);
      check(vi, "word_count", words, v.exp_words);
      check(vi, "read_count", reads, v.exp_words);
      check(vi, "cfg_err_at_done", err_at_done, v.exp_err);
      @(posedge clk);
      #2;
      check(vi, "busy_after_done", int'(busy), 0);
      check(vi, "done_one_cycle", int'(done), 0);
      check(vi, "cfg_err_sticky", int'(cfg_err), v.exp_err);
   endtask

   task automatic check_all_zero(input int vi);
      check(vi, "rst_r_en", int'(r_en), 0);
      check(vi, "rst_r_addr", int'(r_addr), 0);
      check(vi, "rst_w_valid", int'(w_valid), 0);
      check(vi, "rst_w_last", int'(w_last), 0);
      check(vi, "rst_w_data", int'(w_data), 0);
      check(vi, "rst_busy", int'(busy), 0);
      check(vi, "rst_done", int'(done), 0);
      check(vi, "rst_cfg_err", int'(cfg_err), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int reads, cyc;
      //           s    c  p  rdy dly rst words first done err
      tbl[0] = '{  3,   2, 2, 0,  0,  0,  12,   2,   15,  0};
      tbl[1] = '{  3,   2, 2, 1,  0,  0,  12,   2,   25,  0};
      tbl[2] = '{  3,   2, 2, 0, 10,  0,  12,  12,   25,  0};
      tbl[3] = '{200,   2, 1, 0,  0,  0,   0,   0,    1,  1};
      tbl[4] = '{  0,   2, 2, 0,  0,  0,   0,   0,    1,  0};
      tbl[5] = '{  3,   2, 2, 0,  0,  5,  12,   2,   15,  0};
      tbl[6] = '{  1,   1, 1, 0,  0,  0,   1,   2,    4,  0};
      tbl[7] = '{112,   2, 1, 0,  0,  0, 224,   2,  227,  0};
      tbl[8] = '{225,   1, 1, 0,  0,  0,   0,   0,    1,  1};
      tbl[9] = '{  4,   3, 0, 0,  0,  0,   0,   0,    1,  0};

      reset     = 1'b0;
      start     = 1'b0;
      filt_size = '0;
      num_chan  = '0;
      num_pass  = '0;
      spad_full = 1'b0;
      w_ready   = 1'b0;
      spad_dout = '0;
      repeat (3) @(posedge clk);
      #2;
      check_all_zero(100);
      reset = 1'b1;
      @(posedge clk);
      #2;

      for (int i = 0; i < 10; i++) begin
         run_job(i);
      end

      // Reset while idle clears a sticky cfg_err.
      run_job(3);
      reset = 1'b0;
      @(posedge clk);
      #2;
      check(101, "cfg_err_cleared_by_reset", int'(cfg_err), 0);
      check(101, "busy_in_reset", int'(busy), 0);
      reset = 1'b1;
      @(posedge clk);
      #2;

      // Reset mid-RUN after four reads, then a fresh job must replay from address 0.
      filt_size = 8'd3;
      num_chan  = 8'd2;
      num_pass  = 8'd2;
      spad_full = 1'b1;
      w_ready   = 1'b1;
      start     = 1'b1;
      reads     = 0;
      cyc       = 0;
      while (reads < 4 && cyc < 50) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
         #1;
         if (r_en) reads++;
      end
      check(102, "reads_before_reset", reads, 4);
      check(102, "busy_before_reset", int'(busy), 1);
      reset = 1'b0;
      @(posedge clk);
      #2;
      check_all_zero(102);
      reset = 1'b1;
      @(posedge clk);
      #2;
      run_job(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/filter_spad_sequencer.md
# filter_spad_sequencer

Read-side controller for the PE filter scratchpad: once the filter spad is loaded, it generates the `r_en`/`r_addr` sequence that replays the stored filter row for every output position of a 1-D convolution pass. Each word it reads is presented to the MAC datapath on a valid/ready stream, tagged with a per-pass `w_last`. It sits directly downstream of the filter spad and upstream of the multiply-accumulate stage.

## Interface
- `DATA_WIDTH`, 16: filter word width; matches the spad.
- `MEM_DEPTH`, 224: spad depth in words.
- `ADDR_WIDTH`, $clog2(MEM_DEPTH): spad address width.
- `CNT_WIDTH`, 8: width of the channel and pass counts.

- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-low reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `filt_size`  in  ADDR_WIDTH: taps per channel, S; latched on start.
- `num_chan`  in  CNT_WIDTH: channels per pass, C; latched on start.
- `num_pass`  in  CNT_WIDTH: output positions, P; latched on start.
- `spad_full`  in  1: spad load-complete flag.
- `r_en`  out  1: spad read enable.
- `r_addr`  out  ADDR_WIDTH: spad read address.
- `spad_dout`  in  DATA_WIDTH: spad read data; valid one posedge after the issuing cycle.
- `w_data`  out  DATA_WIDTH: filter word to the MAC.
- `w_valid`  out  1: `w_data` valid.
- `w_ready`  in  1: MAC accepts the word.
- `w_last`  out  1: marks the final word of the current pass (address S*C-1).
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at the end of the job.
- `cfg_err`  out  1: S*C > MEM_DEPTH; sticky until the next accepted start.

## Operation
- States:
  - IDLE → WAIT_FULL on `start`.
  - WAIT_FULL → RUN when `spad_full` is sampled high.
  - RUN → DRAIN after the last read has issued.
  - DRAIN → DONE when the output buffer is empty and no read is in flight.
  - DONE → IDLE, always after one cycle.
- Degenerate config: on start, if any of S, C or P is 0, go IDLE → DONE with no reads.
- Config error: on start, compute N = S*C in ADDR_WIDTH+CNT_WIDTH bits. If N > MEM_DEPTH, set `cfg_err` and go to DONE with no reads.
- Address sequence: r_addr = 0,1,…,N-1, repeated P times. Total reads = N*P.
  - The pass counter increments when the address wraps from N-1 to 0.
- Output buffer: 2-entry FIFO holding {data, last}.
  - A read issues only when (FIFO occupancy + reads in flight) < 2, so no word is ever dropped.
  - The last flag is computed at issue time (r_addr == N-1) and travels with its read.
- `w_valid` = FIFO not empty. `w_data`/`w_last` come from the FIFO head. A word is popped on `w_valid && w_ready`.
- `start` during `busy` is ignored. Config inputs are don't-care outside the start cycle.
- `spad_full` falling during RUN does not stall or abort the job; it is checked only in WAIT_FULL.
- Reset low, at any time including mid-job:
  - next state IDLE; FIFO and counters cleared.
  - r_en, r_addr, w_valid, w_last, w_data, busy, done and cfg_err all 0.
  - in-flight read data is discarded.

## Timing
- r_en and r_addr are registered. The spad samples them on the following negedge, so `spad_dout` is captured at the next posedge (read latency 1).
- With `start` sampled at edge T and `spad_full` already high:
  - WAIT_FULL from T+1, RUN from T+2.
  - First r_en (addr 0) in cycle T+2.
  - First w_valid in cycle T+3.
- With `w_ready` held high: one read per cycle, one word per cycle, no bubbles across pass boundaries.
- With `w_ready` low: at most 2 words are buffered; r_en stays low until a slot frees. r_addr holds its value while r_en is low.
- `done` pulses in the cycle after the final handshake (DONE state). `busy` falls in the same cycle `done` falls.
- For an error or degenerate start at edge T: `done` pulses in cycle T+1 and r_en is never asserted.

## Test plan
- S=3, C=2, P=2, spad_full high, w_ready=1 → r_addr 0..5,0..5 on consecutive cycles; 12 words with w_last on words 6 and 12; first r_en at T+2; done at T+15.
- Same config, w_ready toggled 1,0,0,1 repeatedly → word order and data identical to the first case; FIFO never exceeds 2; no r_en while FIFO plus in-flight reads = 2.
- spad_full held low 10 cycles after start, then raised → FSM stays in WAIT_FULL with r_en=0; first r_en 1 cycle after spad_full is sampled high.
- S=200, C=2 → cfg_err=1, done pulses at T+1, zero reads. Then S=0 → done with cfg_err cleared.
- reset low mid-RUN (after 4 reads) → next cycle all outputs 0, FSM in IDLE; a fresh start replays from addr 0.
- start re-asserted while busy → ignored; word count unchanged.
